// File: rtl/sobel_frame_sequencer_pkg.sv
// sobel_frame_sequencer_pkg: shared image geometry defaults, sequencer states and helpers.
package sobel_frame_sequencer_pkg;
  localparam int IMG_WIDTH_DEF  = 16;
  localparam int IMG_HEIGHT_DEF = 16;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_STREAM, S_FLUSH, S_DONE} seq_state_e;

  function automatic logic on_edge(input int pos, input int size);
    return (pos == 0) || (pos == size - 1);
  endfunction
endpackage

// File: rtl/sobel_pos_counter.sv
// sobel_pos_counter: row/column raster counter, column-first, wrapping to (0,0) after (H-1,W-1).
module sobel_pos_counter #(
  parameter int W  = 16,
  parameter int H  = 16,
  parameter int PW = 4
) (
  input  logic          clk_i,
  input  logic          nreset_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [PW-1:0] row_o,
  output logic [PW-1:0] col_o,
  output logic          last_o
);
  logic [PW-1:0] row_q, row_d, col_q, col_d;
  logic          col_last, row_last;

  always_comb begin
    col_last = col_q == PW'(W - 1);
    row_last = row_q == PW'(H - 1);
    col_d    = col_last ? '0 : col_q + PW'(1);
    row_d    = col_last ? (row_last ? '0 : row_q + PW'(1)) : row_q;
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (clr_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (en_i) begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = col_last && row_last;
endmodule

// File: rtl/sobel_frame_sequencer.sv
// sobel_frame_sequencer: counts pixels, sequences window shifts and drains the pipeline at frame end.
// Defining SOBEL_SEQ_STATS_EN adds frame_cnt_o, a count of completed frames.
module sobel_frame_sequencer
  import sobel_frame_sequencer_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int POS_W      = $clog2((IMG_WIDTH > IMG_HEIGHT) ? IMG_WIDTH : IMG_HEIGHT)
) (
  input  logic             clk_i,
  input  logic             nreset_i,
  input  logic             px_valid_i,
  input  logic             abort_i,
  output logic             shift_en_o,
  output logic             win_valid_o,
  output logic             border_o,
  output logic [POS_W-1:0] ctr_row_o,
  output logic [POS_W-1:0] ctr_col_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             overrun_o
`ifdef SOBEL_SEQ_STATS_EN
  ,
  output logic [15:0]      frame_cnt_o
`endif
);
  seq_state_e       state_q;
  logic             shift_q, win_q, border_q, done_q, overrun_q;
  logic [POS_W-1:0] ctr_row_q, ctr_col_q;
  logic [POS_W-1:0] in_row, in_col, c_row, c_col;
  logic             in_last, c_last;
  logic             abort, accept, drop, fill_hit, flushing, win_shift;

  always_comb begin
    abort     = abort_i && (state_q != S_IDLE);
    accept    = px_valid_i && !abort_i && (state_q inside {S_IDLE, S_FILL, S_STREAM});
    drop      = px_valid_i && !abort_i && (state_q inside {S_FLUSH, S_DONE});
    // input index k == LAG is position (1,1) of the input raster
    fill_hit  = (state_q == S_FILL) && (in_row == POS_W'(1)) && (in_col == POS_W'(1));
    flushing  = (state_q == S_FLUSH) && !abort_i;
    win_shift = (accept && ((state_q == S_STREAM) || fill_hit)) || flushing;
  end

  sobel_pos_counter #(.W(IMG_WIDTH), .H(IMG_HEIGHT), .PW(POS_W)) u_in_pos (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .clr_i    (abort),
    .en_i     (accept),
    .row_o    (in_row),
    .col_o    (in_col),
    .last_o   (in_last)
  );

  sobel_pos_counter #(.W(IMG_WIDTH), .H(IMG_HEIGHT), .PW(POS_W)) u_ctr_pos (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .clr_i    (abort),
    .en_i     (win_shift),
    .row_o    (c_row),
    .col_o    (c_col),
    .last_o   (c_last)
  );

`ifdef SOBEL_SEQ_STATS_EN
  logic [15:0] frame_cnt_q;
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) frame_cnt_q <= '0;
    else if (state_q == S_DONE && !abort_i) frame_cnt_q <= frame_cnt_q + 16'd1;
  end
  assign frame_cnt_o = frame_cnt_q;
`endif

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q   <= S_IDLE;
      shift_q   <= 1'b0;
      win_q     <= 1'b0;
      border_q  <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      ctr_row_q <= '0;
      ctr_col_q <= '0;
    end else begin
      shift_q   <= accept || flushing;
      win_q     <= win_shift;
      border_q  <= win_shift && (on_edge(int'(c_row), IMG_HEIGHT) || on_edge(int'(c_col), IMG_WIDTH));
      done_q    <= (state_q == S_DONE) && !abort_i;
      overrun_q <= (state_q == S_IDLE && accept) ? 1'b0 : (overrun_q || drop);
      if (win_shift) begin
        ctr_row_q <= c_row;
        ctr_col_q <= c_col;
      end
      if (abort) state_q <= S_IDLE;
      else begin
        case (state_q)
          S_IDLE:   if (accept) state_q <= S_FILL;
          S_FILL:   if (accept && fill_hit) state_q <= S_STREAM;
          S_STREAM: if (accept && in_last) state_q <= S_FLUSH;
          S_FLUSH:  if (c_last) state_q <= S_DONE;
          default:  state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign shift_en_o   = shift_q;
  assign win_valid_o  = win_q;
  assign border_o     = border_q;
  assign ctr_row_o    = ctr_row_q;
  assign ctr_col_o    = ctr_col_q;
  assign busy_o       = state_q != S_IDLE;
  assign frame_done_o = done_q;
  assign overrun_o    = overrun_q;
endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// tb_sobel_frame_sequencer: directed checks of the frame sequencer on a 4x4 image.
module tb_sobel_frame_sequencer;
  logic       clk_i, nreset_i, px_valid_i, abort_i;
  logic       shift_en_o, win_valid_o, border_o, busy_o, frame_done_o, overrun_o;
  logic [1:0] ctr_row_o, ctr_col_o;
`ifdef SOBEL_SEQ_STATS_EN
  logic [15:0] frame_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  int er, ec, wins, inner;

  sobel_frame_sequencer #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
    .clk_i        (clk_i),
    .nreset_i     (nreset_i),
    .px_valid_i   (px_valid_i),
    .abort_i      (abort_i),
    .shift_en_o   (shift_en_o),
    .win_valid_o  (win_valid_o),
    .border_o     (border_o),
    .ctr_row_o    (ctr_row_o),
    .ctr_col_o    (ctr_col_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .overrun_o    (overrun_o)
`ifdef SOBEL_SEQ_STATS_EN
    ,
    .frame_cnt_o  (frame_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string p);
    chk({p, "_shift"}, 16'(shift_en_o), 16'd0);
    chk({p, "_win"}, 16'(win_valid_o), 16'd0);
    chk({p, "_border"}, 16'(border_o), 16'd0);
    chk({p, "_row"}, 16'(ctr_row_o), 16'd0);
    chk({p, "_col"}, 16'(ctr_col_o), 16'd0);
    chk({p, "_busy"}, 16'(busy_o), 16'd0);
    chk({p, "_done"}, 16'(frame_done_o), 16'd0);
    chk({p, "_overrun"}, 16'(overrun_o), 16'd0);
  endtask

  // Drive one cycle of inputs, then check the registered response to them.
  task automatic tick(input logic px, input logic ab, input logic es, input logic ew, input logic ed);
    px_valid_i = px;
    abort_i    = ab;
    @(posedge clk_i);
    #1;
    px_valid_i = 1'b0;
    abort_i    = 1'b0;
    chk("shift_en", 16'(shift_en_o), 16'(es));
    chk("win_valid", 16'(win_valid_o), 16'(ew));
    chk("frame_done", 16'(frame_done_o), 16'(ed));
    if (ew) begin
      chk("ctr_row", 16'(ctr_row_o), 16'(er));
      chk("ctr_col", 16'(ctr_col_o), 16'(ec));
      chk("border", 16'(border_o), 16'(er == 0 || er == 3 || ec == 0 || ec == 3));
      if (ec == 3) begin
        ec = 0;
        er = (er == 3) ? 0 : er + 1;
      end else ec++;
    end
    if (win_valid_o) wins++;
    if (win_valid_o && !border_o) inner++;
  endtask

  task automatic run_frame(input int ovr_at);
    er = 0; ec = 0; wins = 0; inner = 0;
    for (int k = 0; k < 16; k++) tick(1'b1, 1'b0, 1'b1, k >= 5, 1'b0);
    chk("busy_in_frame", 16'(busy_o), 16'd1);
    for (int f = 0; f < 5; f++) tick(f == ovr_at, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("wins_total", 16'(wins), 16'd16);
    chk("wins_inner", 16'(inner), 16'd4);
    chk("busy_after_done", 16'(busy_o), 16'd0);
  endtask

  initial begin
    nreset_i = 1'b0; px_valid_i = 1'b0; abort_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_idle("rst");
    nreset_i = 1'b1;
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_idle("post_rst");

    // spaced pixels: shift one cycle after each pulse, flush runs back-to-back
    er = 0; ec = 0; wins = 0; inner = 0;
    for (int k = 0; k < 16; k++) begin
      tick(1'b1, 1'b0, 1'b1, k >= 5, 1'b0);
      if (k < 15) repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    repeat (5) tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("spaced_wins", 16'(wins), 16'd16);
    chk("spaced_inner", 16'(inner), 16'd4);
    chk("spaced_last_row", 16'(ctr_row_o), 16'd3);
    chk("spaced_last_col", 16'(ctr_col_o), 16'd3);

    // back-to-back frame
    run_frame(-1);
    chk("b2b_overrun", 16'(overrun_o), 16'd0);

    // abort after 7 pixels, abort colliding with a pixel
    er = 0; ec = 0;
    for (int k = 0; k < 7; k++) tick(1'b1, 1'b0, 1'b1, k >= 5, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("abort_busy", 16'(busy_o), 16'd0);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(-1);

    // pixel during the second flush cycle
    run_frame(1);
    chk("overrun_set", 16'(overrun_o), 16'd1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("overrun_sticky", 16'(overrun_o), 16'd1);
    er = 0; ec = 0;
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("overrun_clear", 16'(overrun_o), 16'd0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("abort2_busy", 16'(busy_o), 16'd0);

    // reset mid-frame discards it
    repeat (3) tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    nreset_i = 1'b0;
    #1;
    chk_idle("mid_rst");
    @(posedge clk_i);
    #1;
    nreset_i = 1'b1;
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SOBEL_SEQ_STATS_EN
    chk("frame_cnt_rst", frame_cnt_o, 16'd0);
`endif

    // three complete frames and one aborted one
    repeat (3) run_frame(-1);
    er = 0; ec = 0;
    repeat (3) tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SOBEL_SEQ_STATS_EN
    chk("frame_cnt", frame_cnt_o, 16'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sobel_frame_sequencer.md
Name: sobel_frame_sequencer

Overview:
Frame-level controller for the Sobel datapath. It sits between spi_control, which delivers one gray pixel per SPI transfer, and the 3x3 line-buffer/Sobel kernel. It counts incoming pixels, sequences line-buffer shifts, and flags when the 3x3 window centre is valid and when it lies on the image border. At frame end it drains the pipeline with internal flush shifts and reports completion, overruns and aborts.

Parameters:
IMG_WIDTH, 16, pixels per row (>=3)
IMG_HEIGHT, 16, rows per frame (>=3)
POS_W, $clog2(max(IMG_WIDTH,IMG_HEIGHT)), width of row/column outputs

Ports:
clk_i  in  1  system clock
nreset_i  in  1  asynchronous active-low reset
px_valid_i  in  1  one-cycle pulse: new pixel latched by spi_control
abort_i  in  1  synchronized CS deassert; terminates the frame
shift_en_o  out  1  advance line buffers/window by one pixel
win_valid_o  out  1  window centre is a real image pixel; qualifies the Sobel output
border_o  out  1  centre lies on row 0/H-1 or column 0/W-1; datapath forces output to 0
ctr_row_o  out  POS_W  centre row of the current window
ctr_col_o  out  POS_W  centre column of the current window
busy_o  out  1  frame in progress (state != S_IDLE)
frame_done_o  out  1  one-cycle pulse after the final flush shift
overrun_o  out  1  sticky: pixel arrived during S_FLUSH/S_DONE
frame_cnt_o  out  16  completed frames (only with the optional feature)

Behaviour:
- Reset: all outputs 0; state S_IDLE; all counters 0. Reset mid-frame discards the frame with no frame_done_o.
- N = IMG_WIDTH*IMG_HEIGHT. LAG = IMG_WIDTH+1.
- Input index k counts accepted pixels. Centre index is k-LAG.
- Latency: shift_en_o is registered and asserts exactly 1 cycle after each accepted px_valid_i.
- win_valid_o, border_o and ctr_* are valid in the same cycle as shift_en_o.
- FSM:
  - S_IDLE: on px_valid_i, accept pixel k=0, clear overrun_o, go to S_FILL.
  - S_FILL: accept pixels; shifts carry win_valid_o=0. When the accepted pixel reaches k=LAG, go to S_STREAM. That shift is the first with win_valid_o=1, centre (0,0).
  - S_STREAM: each accepted pixel gives shift_en_o=1 and win_valid_o=1. The centre counter advances col-first; column wraps to 0 at IMG_WIDTH-1 and row increments. After accepting k=N-1, go to S_FLUSH.
  - S_FLUSH: generate LAG internal shifts on consecutive cycles, each with win_valid_o=1, continuing the centre sequence to (H-1,W-1). Then go to S_DONE.
  - S_DONE: frame_done_o=1 for one cycle, then go to S_IDLE.
- Centre counters wrap to (0,0) after (H-1,W-1).
- px_valid_i in S_FLUSH/S_DONE: pixel dropped, overrun_o set, flush count unaffected.
- abort_i in any non-idle state: go to S_IDLE next cycle, clear counters, no frame_done_o, no shift that cycle.
- abort_i together with px_valid_i: abort wins and the pixel is dropped.
- Back-to-back px_valid_i (every cycle) is supported with no loss.

Optional Feature:
SOBEL_SEQ_STATS_EN:
- Defined: port frame_cnt_o exists. It increments, wrapping at 2^16, on each frame_done_o. Reset value 0. Aborted frames are not counted.
- Undefined: port and counter are absent; no other behaviour change.

Decomposition:
- Add to the shared parameters.svh package: IMG_WIDTH/IMG_HEIGHT defaults and typedef enum logic [2:0] seq_state_e {S_IDLE, S_FILL, S_STREAM, S_FLUSH, S_DONE}.
- One sub-module: sobel_pos_counter, a row/column wrap counter with enable and sync clear. Instantiate it twice: input position (k) and centre position.

Test Plan:
All scenarios use IMG_WIDTH=4, IMG_HEIGHT=4 (N=16, LAG=5).
1. Reset -> all outputs 0, busy_o=0. Release reset with no stimulus -> outputs stay 0.
2. 16 px_valid_i pulses spaced 4 cycles apart ->
   - shift_en_o 1 cycle after each pulse.
   - first win_valid_o on the shift for k=5, centre (0,0), border_o=1.
   - centre (1,1) on the shift for k=10, border_o=0.
   - 11 valid windows from input, then 5 flush shifts on consecutive cycles ending at (3,3).
   - frame_done_o 1 cycle later.
   - in total 16 win_valid_o, 4 with border_o=0.
3. 16 pulses on consecutive cycles -> same 16-window sequence with no gaps; frame_done_o 22 cycles after the first pulse.
4. abort_i after 7 pixels -> S_IDLE, no frame_done_o. Next frame starts at k=0; its first window is centre (0,0) on its 6th pixel.
5. px_valid_i during the 2nd flush cycle -> overrun_o=1, still 5 flush shifts. overrun_o clears on the next frame's first pixel.
6. SOBEL_SEQ_STATS_EN defined: three complete frames plus one aborted frame -> frame_cnt_o=3.
